// File: rtl/VX_tcu_pkg.sv
// rtl/VX_tcu_pkg.sv - shared TCU integer-format types and helpers
package VX_tcu_pkg;

  typedef enum logic [1:0] {
    S8 = 2'd0,
    U8 = 2'd1,
    S4 = 2'd2,
    U4 = 2'd3
  } tcu_ifmt_t;

  // Widest integer operand element handled by the chained FEDP
  localparam int TCU_FEDP_CHAIN_MAXW = 8;

  function automatic logic tcu_ifmt_signed(input tcu_ifmt_t f);
    return (f == S8) || (f == S4);
  endfunction

endpackage

// File: rtl/tcu_fedp_chain_reduce.sv
// rtl/tcu_fedp_chain_reduce.sv - combinational int8/int4 products and adder tree for one beat
module tcu_fedp_chain_reduce
  import VX_tcu_pkg::*;
#(
  parameter int N = 2,
  localparam int SUM_W = 19 + $clog2(8 * N)
) (
  input  logic [1:0]              fmt,
  input  logic [N*32-1:0]         a_row,
  input  logic [N*32-1:0]         b_col,
  output logic signed [SUM_W-1:0] sum
);

  localparam int EW = TCU_FEDP_CHAIN_MAXW;

  tcu_ifmt_t f;
  logic      sgn;
  logic      is4;

  assign f   = tcu_ifmt_t'(fmt);
  assign sgn = tcu_ifmt_signed(f);
  assign is4 = (f == S4) || (f == U4);

  logic signed [SUM_W-1:0] p8 [4*N];
  logic signed [SUM_W-1:0] p4 [8*N];

  genvar i;
  for (i = 0; i < 4 * N; i++) begin : g_p8
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    assign ea = a_row[EW*i +: EW];
    assign eb = b_col[EW*i +: EW];
    assign p8[i] = $signed({{(SUM_W-EW){sgn & ea[EW-1]}}, ea})
                 * $signed({{(SUM_W-EW){sgn & eb[EW-1]}}, eb});
  end

  for (i = 0; i < 8 * N; i++) begin : g_p4
    logic [3:0] ea;
    logic [3:0] eb;
    assign ea = a_row[4*i +: 4];
    assign eb = b_col[4*i +: 4];
    assign p4[i] = $signed({{(SUM_W-4){sgn & ea[3]}}, ea})
                 * $signed({{(SUM_W-4){sgn & eb[3]}}, eb});
  end

  logic signed [SUM_W-1:0] s8;
  logic signed [SUM_W-1:0] s4;

  // Sum both product sets and pick the one matching the operand width
  always_comb begin
    s8 = '0;
    s4 = '0;
    for (int k = 0; k < 4 * N; k++) s8 = s8 + p8[k];
    for (int k = 0; k < 8 * N; k++) s4 = s4 + p4[k];
    sum = is4 ? s4 : s8;
  end

endmodule

// File: rtl/tcu_fedp_chain.sv
// rtl/tcu_fedp_chain.sv - chained integer dot-product engine; TCU_FEDP_SAT_EN enables int32 saturation
module tcu_fedp_chain
  import VX_tcu_pkg::*;
#(
  parameter int N         = 2,
  parameter int MAX_BEATS = 4,
  parameter int MUL_LAT   = 1,
  parameter int ACC_W     = 48
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_first,
  input  logic            in_last,
  input  logic [1:0]      fmt,
  input  logic [N*32-1:0] a_row,
  input  logic [N*32-1:0] b_col,
  input  logic [31:0]     c_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     d_val,
  output logic            err
);

  localparam int SUM_W = 19 + $clog2(8 * N);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int L     = MUL_LAT;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CHAIN = 1'b1;

  logic en;
  logic beat_fire;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en && !reset;
  assign beat_fire = in_valid && in_ready;

  logic signed [SUM_W-1:0] beat_sum;

  tcu_fedp_chain_reduce #(.N(N)) u_reduce (
    .fmt   (fmt),
    .a_row (a_row),
    .b_col (b_col),
    .sum   (beat_sum)
  );

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             eff_first;
  logic             force_last;
  logic             eff_last;
  logic             proto_err;

  // Resolve the effective first/last flags and protocol violations of the offered beat
  always_comb begin
    eff_first  = (state == ST_IDLE) || in_first;
    force_last = (state == ST_CHAIN) && !in_first && !in_last
               && (cnt == CNT_W'(MAX_BEATS - 1));
    eff_last   = in_last || force_last;
    proto_err  = ((state == ST_IDLE) && !in_first)
               || ((state == ST_CHAIN) && in_first)
               || force_last;
  end

  // Chain tracking FSM and sticky error flag, stepped on accepted beats
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else if (beat_fire) begin
      state <= eff_last ? ST_IDLE : ST_CHAIN;
      cnt   <= eff_first ? CNT_W'(1) : cnt + CNT_W'(1);
      if (proto_err) err <= 1'b1;
    end
  end

  logic [L-1:0]            p_valid;
  logic [L-1:0]            p_first;
  logic [L-1:0]            p_last;
  logic signed [SUM_W-1:0] p_sum [L];
  logic [31:0]             p_c   [L];

  // Pipe valids; cleared on reset so in-flight beats are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= '0;
    end else if (en) begin
      p_valid[0] <= beat_fire;
      for (int i = 1; i < L; i++) p_valid[i] <= p_valid[i-1];
    end
  end

  // Pipe payload: beat sum, addend and chain flags move together
  always_ff @(posedge clk) begin
    if (en) begin
      p_sum[0]   <= beat_sum;
      p_c[0]     <= c_val;
      p_first[0] <= eff_first;
      p_last[0]  <= eff_last;
      for (int i = 1; i < L; i++) begin
        p_sum[i]   <= p_sum[i-1];
        p_c[i]     <= p_c[i-1];
        p_first[i] <= p_first[i-1];
        p_last[i]  <= p_last[i-1];
      end
    end
  end

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] sum_ext;
  logic [31:0]             result;

  // Next accumulator value and its 32-bit conversion
  always_comb begin
    sum_ext  = {{(ACC_W-SUM_W){p_sum[L-1][SUM_W-1]}}, p_sum[L-1]};
    acc_next = p_first[L-1] ? ({{(ACC_W-32){p_c[L-1][31]}}, p_c[L-1]} + sum_ext)
                            : (acc + sum_ext);
`ifdef TCU_FEDP_SAT_EN
    if (!acc_next[ACC_W-1] && (|acc_next[ACC_W-2:31]))
      result = 32'h7FFF_FFFF;
    else if (acc_next[ACC_W-1] && !(&acc_next[ACC_W-2:31]))
      result = 32'h8000_0000;
    else
      result = acc_next[31:0];
`else
    result = acc_next[31:0];
`endif
  end

  // Accumulate stage
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en && p_valid[L-1]) begin
      acc <= acc_next;
    end
  end

  // One-entry output buffer; a new result overwrites only a consumed or empty slot
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      d_val     <= '0;
    end else if (en) begin
      if (p_valid[L-1] && p_last[L-1]) begin
        out_valid <= 1'b1;
        d_val     <= result;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcu_fedp_chain.sv
// tb/tb_tcu_fedp_chain.sv - scoreboard bench for tcu_fedp_chain
module tb_tcu_fedp_chain;

  localparam int N       = 2;
  localparam int MUL_LAT = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_first, in_last;
  logic [1:0]    fmt;
  logic [N*32-1:0] a_row, b_col;
  logic [31:0]   c_val, d_val;
  logic          out_valid, out_ready, err;

  tcu_fedp_chain #(.N(N), .MAX_BEATS(4), .MUL_LAT(MUL_LAT), .ACC_W(48)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .fmt(fmt), .a_row(a_row), .b_col(b_col), .c_val(c_val),
    .out_valid(out_valid), .out_ready(out_ready), .d_val(d_val), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int received = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  function automatic longint beat_model(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    int ea, eb;
    if (f < 2) begin
      for (int k = 0; k < 8; k++) begin
        ea = int'(a[8*k +: 8]);
        eb = int'(b[8*k +: 8]);
        if (f == 0) begin
          if (ea > 127) ea -= 256;
          if (eb > 127) eb -= 256;
        end
        s += longint'(ea * eb);
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        ea = int'(a[4*k +: 4]);
        eb = int'(b[4*k +: 4]);
        if (f == 2) begin
          if (ea > 7) ea -= 16;
          if (eb > 7) eb -= 16;
        end
        s += longint'(ea * eb);
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] to_result(input longint acc);
`ifdef TCU_FEDP_SAT_EN
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  function automatic longint sext_c(input logic [31:0] c);
    return longint'($signed(c));
  endfunction

  // Output monitor: pops the scoreboard on every completed result handshake
  always begin
    @(negedge clk);
    #3;
    if (!reset && out_valid && out_ready) begin
      checks++;
      received++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=%h required=none", d_val);
      end else begin
        mon_exp = exp_q.pop_front();
        if (d_val !== mon_exp) begin
          errors++;
          $display("FAIL d_val got=%h required=%h", d_val, mon_exp);
        end
      end
    end
  end

  task automatic send_beat(input logic f, input logic l, input logic [1:0] fm,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [31:0] c, output int waits);
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1; in_first = f; in_last = l;
    fmt = fm; a_row = a; b_col = b; c_val = c;
    forever begin
      #4;
      if (in_ready) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      waits++;
      if (waits > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got=no_accept required=accept");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d_pending required=0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    fmt = 2'd0; a_row = '0; b_col = '0; c_val = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    checks++;
    if (out_valid !== 1'b0 || d_val !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=ov%b d%h e%b required=ov0 d00000000 e0", out_valid, d_val, err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset got=%b required=0", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b required=1", in_ready);
    end
  endtask

  task automatic test_two_beat_s8();
    int w;
    exp_q.push_back(32'h0000_0025);
    send_beat(1'b1, 1'b0, 2'd0, {2{32'h0101_0101}}, {2{32'h0202_0202}}, 32'd5, w);
    send_beat(1'b0, 1'b1, 2'd0, {2{32'h0101_0101}}, {2{32'h0202_0202}}, 32'd0, w);
    idle();
    wait_drain();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL s8_err got=%b required=0", err);
    end
  endtask

  task automatic test_s4_latency();
    int w, n;
    exp_q.push_back(32'hFFFF_FFF0);
    send_beat(1'b1, 1'b1, 2'd2, {2{32'hFFFF_FFFF}}, {2{32'h1111_1111}}, 32'd0, w);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      #3;
      if (out_valid) break;
      n++;
    end
    checks++;
    if (n != MUL_LAT + 1) begin
      errors++;
      $display("FAIL latency got=%0d required=%0d", n, MUL_LAT + 1);
    end
    wait_drain();
  endtask

  task automatic test_u8_overflow();
    int w;
`ifdef TCU_FEDP_SAT_EN
    exp_q.push_back(32'h7FFF_FFFF);
`else
    exp_q.push_back(32'h8007_EFF8);
`endif
    send_beat(1'b1, 1'b1, 2'd1, {2{32'hFFFF_FFFF}}, {2{32'hFFFF_FFFF}}, 32'h7FFF_FFF0, w);
    idle();
    wait_drain();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL u8_err got=%b required=0", err);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] va[10], vb[10];
    logic [31:0] vc[10];
    logic [1:0]  vf[10];
    int w, total, rx0;
    rx0 = received;
    for (int i = 0; i < 10; i++) begin
      va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom};
      vc[i] = $urandom; vf[i] = 2'($urandom_range(0, 3));
      exp_q.push_back(to_result(sext_c(vc[i]) + beat_model(vf[i], va[i], vb[i])));
    end
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(1'b1, 1'b1, vf[i], va[i], vb[i], vc[i], w);
        idle();
      end
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk); #3;
          if (out_valid) break;
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #3;
          checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_%0d got=ov%b rdy%b required=ov1 rdy0", k, out_valid, in_ready);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_release got=%b required=1", in_ready);
        end
      end
    join
    wait_drain();
    checks++;
    if (received - rx0 != 10) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=10", received - rx0);
    end
    total = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(to_result(sext_c(vc[i]) + beat_model(vf[i], va[i], vb[i])));
      send_beat(1'b1, 1'b1, vf[i], va[i], vb[i], vc[i], w);
      total += w;
    end
    idle();
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL throughput got=%0d_waits required=0", total);
    end
    wait_drain();
  endtask

  task automatic test_protocol();
    logic [63:0] a, b;
    logic [31:0] c, c2;
    longint s;
    int w;
    // beat without first while idle
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = $urandom;
    exp_q.push_back(to_result(sext_c(c) + beat_model(2'd0, a, b)));
    send_beat(1'b0, 1'b1, 2'd0, a, b, c, w);
    idle();
    wait_drain();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_no_first got=%b required=1", err);
    end
    do_reset();
    #3;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got=%b required=0", err);
    end
    // first beat in the middle of a chain restarts it
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = $urandom; c2 = $urandom;
    send_beat(1'b1, 1'b0, 2'd1, a, b, c, w);
    exp_q.push_back(to_result(sext_c(c2) + beat_model(2'd3, b, a)));
    send_beat(1'b1, 1'b1, 2'd3, b, a, c2, w);
    idle();
    wait_drain();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_restart got=%b required=1", err);
    end
    do_reset();
    // chain longer than MAX_BEATS is cut after the fourth beat
    c = $urandom;
    s = sext_c(c);
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if (i < 4) s += beat_model(2'd0, a, b);
      if (i == 3) exp_q.push_back(to_result(s));
      send_beat(i == 0, 1'b0, 2'd0, a, b, (i == 0) ? c : 32'h1234_5678, w);
    end
    idle();
    wait_drain();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_overlong got=%b required=1", err);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_chain();
    logic [63:0] a, b;
    logic [31:0] c;
    longint s;
    int w;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = $urandom;
    send_beat(1'b1, 1'b0, 2'd0, a, b, c, w);
    @(negedge clk);
    in_first = 1'b0; in_last = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_mid_reset got=ov%b e%b required=ov0 e0", out_valid, err);
    end
    repeat (6) @(negedge clk);
    c = $urandom;
    s = sext_c(c);
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      s += beat_model(2'd2, a, b);
      if (i == 2) exp_q.push_back(to_result(s));
      send_beat(i == 0, i == 2, 2'd2, a, b, c, w);
    end
    idle();
    wait_drain();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_full_chain got=%b required=0", err);
    end
  endtask

  initial begin
    test_reset();
    test_two_beat_s8();
    test_s4_latency();
    test_u8_overflow();
    test_back_to_back();
    test_protocol();
    test_reset_mid_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

endmodule
